divider_signed_seq: RTL and testbench

Iterative signed integer divider, the inverse of the signed array multiplier. It computes quotient and remainder of two SIZE-bit two's-complement operands using a radix-2 restoring algorithm, one quotient bit per cycle. Operands arrive and results leave over valid/ready handshakes, so the block sits beside the multiplier in the arithmetic datapath and can be stalled from either side.

---
 rtl/divider_signed_seq.sv | 170 +++++++++++++++++
 tb/tb_divider_signed_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_signed_seq.sv
// Purpose : iterative radix-2 restoring signed divider (quotient truncates toward zero, remainder takes dividend sign).
// Latency : SIZE+2 cycles from input handshake to out_valid; 1 cycle for divide-by-zero and MIN/-1 overflow.
// Backpr. : in_ready only in IDLE; result held in DONE until out_ready, no overlap between operations.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : operand handshake (dividend, divisor, SIZE-bit two's complement)
//   out_valid/out_ready    : result handshake (quotient, remainder, div_by_zero, overflow)
//   busy                   : high while iterating (CALC) or applying signs (FIX)
module divider_signed_seq #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero,
  output logic            overflow,
  output logic            busy
);

  localparam int              CW      = $clog2(SIZE);
  localparam logic [SIZE-1:0] ONE     = SIZE'(1);
  localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_abs_dv;
  // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
  logic [SIZE-1:0] r_quo;
  // Partial remainder. Between iterations it is always below |divisor| <= 2^(SIZE-1),
  // so only the shifted trial value needs the extra (SIZE+1)th bit.
  logic [SIZE-1:0] r_rem;
  logic            r_sign_q;
  logic            r_sign_r;
  logic [SIZE-1:0] r_quotient;
  logic [SIZE-1:0] r_remainder;
  logic            r_dbz;
  logic            r_ovf;

  logic            w_div_zero;
  logic            w_ovf_case;
  logic [SIZE-1:0] w_abs_dd;
  logic [SIZE-1:0] w_abs_dv;
  logic [SIZE:0]   w_shift;
  logic [SIZE:0]   w_diff;
  logic            w_qbit;

  assign w_div_zero = (divisor == '0);
  assign w_ovf_case = (dividend == MIN_VAL) && (divisor == '1);

  // MIN maps to 2^(SIZE-1), which is representable as an unsigned SIZE-bit value.
  assign w_abs_dd = dividend[SIZE-1] ? (~dividend + ONE) : dividend;
  assign w_abs_dv = divisor[SIZE-1]  ? (~divisor + ONE)  : divisor;

  // Trial subtraction: a borrow (MSB set) means the shifted remainder is below the divisor.
  assign w_shift = {r_rem, r_quo[SIZE-1]};
  assign w_diff  = w_shift - {1'b0, r_abs_dv};
  assign w_qbit  = ~w_diff[SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (w_div_zero || w_ovf_case) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_abs_dv    <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign_q <= dividend[SIZE-1] ^ divisor[SIZE-1];
            r_sign_r <= dividend[SIZE-1];
            r_abs_dv <= w_abs_dv;
            r_quo    <= w_abs_dd;
            r_rem    <= '0;
            r_cnt    <= CW'(SIZE - 1);
            r_dbz    <= w_div_zero;
            r_ovf    <= w_ovf_case;
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
            end else if (w_ovf_case) begin
              r_quotient  <= MIN_VAL;
              r_remainder <= '0;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_qbit ? w_diff[SIZE-1:0] : w_shift[SIZE-1:0];
          r_quo <= {r_quo[SIZE-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          // Negating zero yields zero, so a zero result never picks up a sign artefact.
          r_quotient  <= r_sign_q ? (~r_quo + ONE) : r_quo;
          r_remainder <= r_sign_r ? (~r_rem + ONE) : r_rem;
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_divider_signed_seq.sv
// Purpose : randomized + directed bench for divider_signed_seq against a plain-arithmetic reference.
// Latency : expects out_valid SIZE+2 cycles after a normal handshake, 1 cycle for special cases.
// Backpr. : exercises held results with out_ready low and mid-operation reset.
module tb_divider_signed_seq;

  localparam int SIZE = 32;
  localparam logic [31:0] MIN_V = 32'h8000_0000;
  localparam logic [31:0] MAX_V = 32'h7FFF_FFFF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] dividend = '0;
  logic [SIZE-1:0] divisor = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;
  logic            div_by_zero;
  logic            overflow;
  logic            busy;

  divider_signed_seq #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: plain signed arithmetic; SV '/' and '%' truncate toward zero.
  typedef struct {
    logic [31:0] a, b, q, r;
    logic        dbz, ovf;
    int          hs, lat;
  } exp_t;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.a = a; e.b = b; e.dbz = 1'b0; e.ovf = 1'b0; e.hs = 0;
    if (sb == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
    end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
      e.q = MIN_V; e.r = 32'h0; e.ovf = 1'b1;
    end else begin
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
    end
    e.lat = (e.dbz || e.ovf) ? 1 : SIZE + 2;
    return e;
  endfunction

  exp_t        eq[$];
  exp_t        fe;
  bit          front_seen = 0;
  logic [31:0] last_q, last_r;
  logic        last_dbz, last_ovf;
  longint      la, lb, lq, lr;

  // Single compare process: tracks outstanding operations and checks every cycle.
  always @(negedge clk) begin
    if (rst) begin
      eq.delete();
      front_seen = 0;
    end else if (eq.size() == 0) begin
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      if (in_valid && in_ready) begin
        fe = model(dividend, divisor);
        fe.hs = cyc;
        eq.push_back(fe);
      end
    end else begin
      fe = eq[0];
      chk("inflight_in_ready", in_ready, 0);
      chk("inflight_busy", busy, !out_valid);
      if (out_valid) begin
        if (!front_seen) begin
          chk("latency", 64'(cyc - fe.hs), 64'(fe.lat));
          front_seen = 1;
        end
        chk("quotient", quotient, fe.q);
        chk("remainder", remainder, fe.r);
        chk("div_by_zero", div_by_zero, fe.dbz);
        chk("overflow", overflow, fe.ovf);
        if (out_ready) begin
          if (!fe.dbz && !fe.ovf) begin
            la = longint'($signed(fe.a));
            lb = longint'($signed(fe.b));
            lq = longint'($signed(quotient));
            lr = longint'($signed(remainder));
            chk("inv_identity", la, lq * lb + lr);
            chk("inv_magnitude", ((lr < 0 ? -lr : lr) < (lb < 0 ? -lb : lb)), 1);
            chk("inv_sign", (lr == 0) || ((lr < 0) == (la < 0)), 1);
          end
          last_q = quotient; last_r = remainder;
          last_dbz = div_by_zero; last_ovf = overflow;
          void'(eq.pop_front());
          front_seen = 0;
          done_cnt++;
        end
      end else if (cyc - fe.hs >= fe.lat) begin
        chk("out_valid_late", out_valid, 1);
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int start;
    int n;
    start = done_cnt;
    @(posedge clk); #1;
    dividend = a; divisor = b; in_valid = 1'b1; out_ready = (hold == 0);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin fail_now("in_handshake"); break; end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    if (hold > 0) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 100);
      if (!out_valid) fail_now("wait_out_valid");
      repeat (hold) @(negedge clk);
      @(posedge clk); #1 out_ready = 1'b1;
    end
    n = 0;
    while (done_cnt == start && n < 200) begin @(negedge clk); n++; end
    if (done_cnt == start) fail_now("out_handshake");
  endtask

  task automatic chk_res(input string name, input logic [31:0] q, input logic [31:0] r,
                         input logic dbz, input logic ovf);
    chk({name, "_q"}, last_q, q);
    chk({name, "_r"}, last_r, r);
    chk({name, "_dbz"}, last_dbz, dbz);
    chk({name, "_ovf"}, last_ovf, ovf);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = MIN_V;
      4: v = MAX_V;
      5: begin
        v = 32'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) v = ~v + 32'h1;
      end
      6: begin
        v = 32'($urandom_range(0, 65535));
        if ($urandom_range(0, 1) == 1) v = ~v + 32'h1;
      end
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    logic [31:0] a, b;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    @(posedge clk); #1 rst = 1'b0;

    do_op(32'd7, 32'd2, 0);                 chk_res("p7_p2", 32'd3, 32'd1, 0, 0);
    do_op(-32'sd7, 32'd2, 0);               chk_res("n7_p2", -32'sd3, -32'sd1, 0, 0);
    do_op(32'd7, -32'sd2, 0);               chk_res("p7_n2", -32'sd3, 32'd1, 0, 0);
    do_op(-32'sd7, -32'sd2, 0);             chk_res("n7_n2", 32'd3, -32'sd1, 0, 0);
    do_op(32'd5, 32'd0, 0);                 chk_res("div0_5", 32'hFFFF_FFFF, 32'd5, 1, 0);
    do_op(32'd0, 32'd0, 0);                 chk_res("div0_0", 32'hFFFF_FFFF, 32'd0, 1, 0);
    do_op(MIN_V, 32'hFFFF_FFFF, 0);         chk_res("ovf", MIN_V, 32'd0, 0, 1);
    do_op(MIN_V, 32'd2, 0);                 chk_res("min_by_2", 32'hC000_0000, 32'd0, 0, 0);
    do_op(32'd0, -32'sd5, 0);               chk_res("zero_dividend", 32'd0, 32'd0, 0, 0);
    do_op(32'd100, 32'd7, 10);              chk_res("backpressure", 32'd14, 32'd2, 0, 0);

    // Reset while iterating: the aborted result must never surface.
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    do_op(32'd9, 32'd3, 0);                 chk_res("after_rst", 32'd3, 32'd0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      a = rnd_val();
      b = rnd_val();
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_op(a, b, hold);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(eq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
